// File: rtl/astropix_spi_emulator.sv
// ==========================================================================
// astropix_spi_emulator : AstroPix lane readout SPI responder (clk-domain sampled).
// Optional counters via `ASTROPIX_EMU_STATS_EN.                Rev 1.0
// ==========================================================================
`default_nettype none

module astropix_spi_emulator #(
  parameter logic [7:0] IDLE_BYTE   = 8'hBC,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        spi_clk,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic [1:0]  spi_miso,
  output logic        interruptn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        stat_mosi_overflow
`ifdef ASTROPIX_EMU_STATS_EN
  ,
  output logic [15:0] stat_bytes_rx,
  output logic [15:0] stat_frames_tx
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_act, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise;
  logic                   load_now;
  logic [2:0]             bitcnt;
  logic [1:0]             paircnt;
  logic [6:0]             rx_sr;
  logic [7:0]             miso_sr;
  logic                   tail;
  logic                   byte_accept;
  logic                   frame_pop;

  // Synchroniser flops reset to the idle bus levels so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!resn) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_act;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_act    = ~csn_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_act & ~cs_d;

  always_ff @(posedge clk) begin
    if (!resn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_now  = 1'b0;
    case (state)
      ST_IDLE:  if (cs_rise) state_nxt = ST_LOAD;
      ST_LOAD:  begin
        load_now  = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: if (sclk_fall && (paircnt == 2'd3)) load_now = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!cs_act) begin
      state_nxt = ST_IDLE;
      load_now  = 1'b0;
    end
  end

  assign s_axis_tready = load_now;
  assign spi_miso      = miso_sr[{paircnt, 1'b0} +: 2];
  assign frame_pop     = load_now & s_axis_tvalid & s_axis_tlast;

  always_ff @(posedge clk) begin
    if (!resn) begin
      bitcnt             <= 3'd0;
      paircnt            <= 2'd0;
      rx_sr              <= 7'd0;
      miso_sr            <= 8'd0;
      m_axis_tdata       <= 8'd0;
      m_axis_tvalid      <= 1'b0;
      stat_mosi_overflow <= 1'b0;
      tail               <= 1'b0;
      interruptn         <= 1'b1;
      byte_accept        <= 1'b0;
    end else begin
      stat_mosi_overflow <= 1'b0;
      byte_accept        <= 1'b0;
      tail               <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      // Deselect discards any partial MOSI byte and restarts the pair index.
      if (!cs_act) begin
        bitcnt  <= 3'd0;
        paircnt <= 2'd0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt != 3'd7) begin
            rx_sr[bitcnt] <= mosi_s;
          end else if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tdata  <= {mosi_s, rx_sr};
            m_axis_tvalid <= 1'b1;
            byte_accept   <= 1'b1;
          end else begin
            stat_mosi_overflow <= 1'b1;
          end
        end
        if ((state == ST_SHIFT) && sclk_fall) paircnt <= paircnt + 2'd1;
      end

      if (load_now) begin
        if (s_axis_tvalid) begin
          miso_sr <= s_axis_tdata;
          tail    <= s_axis_tlast;
        end else begin
          miso_sr <= IDLE_BYTE;
        end
      end

      // A following frame already waiting when the tlast byte leaves keeps the line low.
      if ((state == ST_IDLE) && s_axis_tvalid) interruptn <= 1'b0;
      else if (tail && !s_axis_tvalid)         interruptn <= 1'b1;
    end
  end

`ifdef ASTROPIX_EMU_STATS_EN
  always_ff @(posedge clk) begin
    if (!resn) begin
      stat_bytes_rx  <= 16'd0;
      stat_frames_tx <= 16'd0;
    end else begin
      if (byte_accept) stat_bytes_rx  <= stat_bytes_rx + 16'd1;
      if (frame_pop)   stat_frames_tx <= stat_frames_tx + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = byte_accept ^ frame_pop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_astropix_spi_emulator.sv
// ==========================================================================
// tb_astropix_spi_emulator : directed + randomized bench with a frame-level model.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_astropix_spi_emulator;

  localparam int         HALF = 8;
  localparam logic [7:0] IDLE = 8'hBC;

  logic        clk = 1'b0;
  logic        resn, spi_clk, spi_csn, spi_mosi;
  logic [1:0]  spi_miso;
  logic        interruptn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic        stat_mosi_overflow;
`ifdef ASTROPIX_EMU_STATS_EN
  logic [15:0] stat_bytes_rx, stat_frames_tx;
`endif

  always #5 clk = ~clk;

  astropix_spi_emulator #(.IDLE_BYTE(8'hBC), .SYNC_STAGES(2)) dut (
    .clk                (clk),
    .resn               (resn),
    .spi_clk            (spi_clk),
    .spi_csn            (spi_csn),
    .spi_mosi           (spi_mosi),
    .spi_miso           (spi_miso),
    .interruptn         (interruptn),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .stat_mosi_overflow (stat_mosi_overflow)
`ifdef ASTROPIX_EMU_STATS_EN
    ,
    .stat_bytes_rx      (stat_bytes_rx),
    .stat_frames_tx     (stat_frames_tx)
`endif
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         ovf_cnt = 0;
  logic [8:0] src_q[$];    // {tlast, data} waiting at the DUT's frame input
  logic [8:0] model_q[$];  // model's view of the same frame bytes
  logic [7:0] m_q[$];      // received MOSI beats
  logic [1:0] miso_q[$];   // MISO pairs sampled just before each rising spi_clk

  always @(negedge clk) begin
    if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      {s_axis_tlast, s_axis_tdata} = src_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 8'd0;
    end
  end

  always @(posedge clk) begin
    if (s_axis_tvalid && s_axis_tready && src_q.size() > 0) void'(src_q.pop_front());
    if (m_axis_tvalid && m_axis_tready) m_q.push_back(m_axis_tdata);
    if (stat_mosi_overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int len);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1), 8'($urandom)};
      src_q.push_back(e);
      model_q.push_back(e);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    src_q.push_back({last, d});
    model_q.push_back({last, d});
  endtask

  task automatic spi_begin();
    miso_q.delete();
    spi_csn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    miso_q.push_back(spi_miso);
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic spi_run(input logic [31:0] mosi, input int nclk);
    spi_begin();
    for (int i = 0; i < nclk; i++) spi_bit(mosi[i]);
    spi_end();
  endtask

  // Model: one MISO byte fetched at select plus one per 4 spi_clk; a complete
  // MOSI byte every 8 spi_clk, LSB first; unused fetched bytes are lost.
  task automatic xfer(input string tag, input logic [31:0] mosi, input int nclk);
    logic [7:0] mb[$];
    logic [8:0] t;
    logic [1:0] ep;
    int         nloads;
    int         nrx;
    nloads = 1 + nclk / 4;
    nrx    = nclk / 8;
    for (int l = 0; l < nloads; l++) begin
      if (model_q.size() > 0) begin
        t = model_q.pop_front();
        mb.push_back(t[7:0]);
      end else begin
        mb.push_back(IDLE);
      end
    end
    m_q.delete();
    ovf_cnt = 0;
    spi_run(mosi, nclk);
    for (int j = 0; j < nclk; j++) begin
      ep = 2'(mb[j / 4] >> (2 * (j % 4)));
      check($sformatf("%s miso[%0d]", tag, j), 32'(miso_q[j]), 32'(ep));
    end
    check({tag, " rx_count"}, m_q.size(), nrx);
    for (int b = 0; b < nrx && b < m_q.size(); b++)
      check($sformatf("%s rx[%0d]", tag, b), 32'(m_q[b]), 32'(8'(mosi >> (8 * b))));
    check({tag, " no_overflow"}, ovf_cnt, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " miso"},     32'(spi_miso), 0);
    check({tag, " intn"},     32'(interruptn), 1);
    check({tag, " s_tready"}, 32'(s_axis_tready), 0);
    check({tag, " m_tvalid"}, 32'(m_axis_tvalid), 0);
    check({tag, " m_tdata"},  32'(m_axis_tdata), 0);
    check({tag, " ovf"},      32'(stat_mosi_overflow), 0);
  endtask

  initial begin
    logic [31:0] r;
    int          n;
    resn = 1'b0; spi_clk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'd0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    resn = 1'b1;
    repeat (10) @(negedge clk);

    xfer("mosi_rx", 32'h3CA5, 16);

    xfer("idle_fill", $urandom, 8);
    check("idle_fill intn", 32'(interruptn), 1);

    push_byte(8'h11, 1'b0); push_byte(8'h22, 1'b0); push_byte(8'h33, 1'b1);
    repeat (3) @(negedge clk);
    check("frame intn_low", 32'(interruptn), 0);
    xfer("frame", $urandom, 16);
    check("frame intn_high", 32'(interruptn), 1);

    m_axis_tready = 1'b0;
    m_q.delete(); ovf_cnt = 0;
    spi_run(32'h0201, 16);
    void'(model_q.size());
    check("bp overflow_pulses", ovf_cnt, 1);
    check("bp m_tvalid", 32'(m_axis_tvalid), 1);
    check("bp m_tdata", 32'(m_axis_tdata), 32'h01);
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp beats", m_q.size(), 1);
    if (m_q.size() > 0) check("bp beat0", 32'(m_q[0]), 32'h01);

    m_q.delete();
    spi_run($urandom, 5);
    check("abort no_beat", m_q.size(), 0);
    xfer("after_abort", 32'h7E, 8);

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 2) != 0) push_frame($urandom_range(1, 5));
      repeat (4) @(negedge clk);
      r = $urandom;
      n = $urandom_range(1, 24);
      xfer($sformatf("rand%0d", it), r, n);
      check($sformatf("rand%0d intn", it), 32'(interruptn), (src_q.size() == 0) ? 1 : 0);
    end

    src_q.delete(); model_q.delete();
    repeat (4) @(negedge clk);
    push_byte(8'hAA, 1'b0); push_byte(8'hBB, 1'b1);
    repeat (4) @(negedge clk);
    spi_begin();
    for (int i = 0; i < 6; i++) spi_bit(1'($urandom));
    resn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    src_q.delete(); model_q.delete();
    spi_csn = 1'b1; spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    resn = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset intn_after", 32'(interruptn), 1);
    xfer("post_reset", $urandom, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
